alarm_seq: RTL and testbench

- Alarm sequencing controller for the digital clock; sits between the time/alarm comparison and the Buzz output.
- Converts a level "time equals alarm" match into a ring/snooze/stop session: bounded ring time, snooze re-arm, snooze count limit.
- Runs on the system clock. Counts seconds using the 1 Hz single-cycle tick enable.

---
 rtl/clock_pkg.sv | 17 +
 rtl/alarm_seq_sec_countdown.sv | 30 +++
 rtl/alarm_seq.sv | 161 ++++++++++++++++
 tb/tb_alarm_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and default timing constants for the digital clock alarm path.
package clock_pkg;

    // Alarm session states; encodings are visible on state_o.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        DONE   = 2'd3
    } alarm_state_t;

    localparam int RING_S_DEF     = 60;
    localparam int SNOOZE_S_DEF   = 540;
    localparam int MAX_SNOOZE_DEF = 3;
    localparam int CW_DEF         = 10;

endpackage

// File: rtl/alarm_seq_sec_countdown.sv
// Loadable, tick-enabled seconds down-counter that saturates at zero.
// Load has priority over decrement, so a load on a tick cycle consumes the tick.
module sec_countdown #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count;

    // Counter register: load wins, otherwise decrement until zero and hold.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alarm_seq.sv
// Alarm sequencing controller: turns the level "time equals alarm" match into
// a ring / snooze / stop session with bounded ring time and a snooze limit.
// Optional build macro ALARM_SEQ_BEEP_EN: buzz toggles on every tick in RING
// (1 s on / 1 s off); without it buzz is a steady 1 throughout RING.
module alarm_seq
    import clock_pkg::*;
#(
    parameter int RING_S     = RING_S_DEF,
    parameter int SNOOZE_S   = SNOOZE_S_DEF,
    parameter int MAX_SNOOZE = MAX_SNOOZE_DEF,
    parameter int CW         = CW_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       alarmon,
    input  logic       match,
    input  logic       snooze,
    input  logic       stop,
    output logic       buzz,
    output logic [1:0] state_o,
    output logic [1:0] snooze_cnt_o
);

    localparam logic [CW-1:0] RING_LOAD   = CW'(RING_S - 1);
    localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_S - 1);
    localparam logic [1:0]    MAX_CNT     = 2'(MAX_SNOOZE);

    alarm_state_t  state, state_nx;
    logic          buzz_nx;
    logic [1:0]    snooze_cnt, snooze_cnt_nx;
    logic          match_q;
    logic          trigger;
    logic          quit;
    logic          cd_load;
    logic [CW-1:0] cd_load_val;
    logic          cd_dec;
    logic          cd_zero;

    // Only a rising match with the alarm enabled starts a session, so turning
    // alarmon on inside a matching minute does not ring.
    assign trigger = match & ~match_q & alarmon;
    // Disabling the alarm and pressing stop end a session the same way.
    assign quit    = ~alarmon | stop;

    sec_countdown #(
        .CW (CW)
    ) u_countdown (
        .clk      (clk),
        .rst      (rst),
        .load     (cd_load),
        .load_val (cd_load_val),
        .dec      (cd_dec),
        .zero     (cd_zero)
    );

    // State, buzzer, snooze count and match history registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: all state resets asynchronously so buzz drops the moment rst falls.
        if (!rst) begin
            state      <= IDLE;
            buzz       <= 1'b0;
            snooze_cnt <= 2'd0;
            match_q    <= 1'b0;
        end else begin
            state      <= state_nx;
            buzz       <= buzz_nx;
            snooze_cnt <= snooze_cnt_nx;
            match_q    <= match;
        end
    end

    // Next-state, next-buzz and countdown control; buttons outrank the tick.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_nx      = state;
        buzz_nx       = buzz;
        snooze_cnt_nx = snooze_cnt;
        cd_load       = 1'b0;
        cd_load_val   = RING_LOAD;
        cd_dec        = 1'b0;

        case (state)
            IDLE: begin
                buzz_nx = 1'b0;
                if (trigger) begin
                    state_nx      = RING;
                    buzz_nx       = 1'b1;
                    snooze_cnt_nx = 2'd0;
                    cd_load       = 1'b1;
                    cd_load_val   = RING_LOAD;
                end
            end

            RING: begin
                if (quit) begin
                    state_nx = DONE;
                    buzz_nx  = 1'b0;
                end else if (snooze) begin
                    buzz_nx = 1'b0;
                    if (snooze_cnt < MAX_CNT) begin
                        state_nx      = SNOOZE;
                        snooze_cnt_nx = snooze_cnt + 2'd1;
                        cd_load       = 1'b1;
                        cd_load_val   = SNOOZE_LOAD;
                    end else begin
                        // Snooze budget exhausted: behaves like stop.
                        state_nx = DONE;
                    end
                end else if (tick) begin
                    if (cd_zero) begin
                        state_nx = DONE;
                        buzz_nx  = 1'b0;
                    end else begin
                        cd_dec = 1'b1;
`ifdef ALARM_SEQ_BEEP_EN
                        buzz_nx = ~buzz;
`else
                        buzz_nx = 1'b1;
`endif
                    end
                end
            end

            SNOOZE: begin
                buzz_nx = 1'b0;
                if (quit) begin
                    state_nx = DONE;
                end else if (tick) begin
                    if (cd_zero) begin
                        state_nx    = RING;
                        buzz_nx     = 1'b1;
                        cd_load     = 1'b1;
                        cd_load_val = RING_LOAD;
                    end else begin
                        cd_dec = 1'b1;
                    end
                end
            end

            DONE: begin
                // Holds until the matching minute has fully passed, which
                // blocks a retrigger within the same minute.
                buzz_nx = 1'b0;
                if (!match && !match_q) begin
                    state_nx      = IDLE;
                    snooze_cnt_nx = 2'd0;
                end
            end

            default: begin
                state_nx = IDLE;
                buzz_nx  = 1'b0;
            end
        endcase
    end

    assign state_o      = state;
    assign snooze_cnt_o = snooze_cnt;

endmodule

// File: tb/tb_alarm_seq.sv
// Self-checking bench for alarm_seq with RING_S=4, SNOOZE_S=3, MAX_SNOOZE=2
// and a tick every 10 clocks. Expected output snapshots are queued when
// stimulus is applied and compared after the clock edge they are due on.
module tb_alarm_seq;

    localparam int S_IDLE   = 0;
    localparam int S_RING   = 1;
    localparam int S_SNOOZE = 2;
    localparam int S_DONE   = 3;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       alarmon;
    logic       match;
    logic       snooze;
    logic       stop;
    logic       buzz;
    logic [1:0] state_o;
    logic [1:0] snooze_cnt_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int phase  = 0;

    typedef struct {
        string      tag;
        int         due;
        logic [1:0] st;
        logic       bz;
        logic [1:0] cnt;
    } exp_t;

    exp_t sb[$];

    alarm_seq #(
        .RING_S     (4),
        .SNOOZE_S   (3),
        .MAX_SNOOZE (2),
        .CW         (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .alarmon      (alarmon),
        .match        (match),
        .snooze       (snooze),
        .stop         (stop),
        .buzz         (buzz),
        .state_o      (state_o),
        .snooze_cnt_o (snooze_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Queue an expected output snapshot, due 'delay' clock edges from now.
    task automatic sb_push(input string tag, input int delay, input int st,
                           input logic bz, input int cnt);
        exp_t e;
        e.tag = tag;
        e.due = cyc + delay;
        e.st  = 2'(st);
        e.bz  = bz;
        e.cnt = 2'(cnt);
        sb.push_back(e);
    endtask

    // One clock: drive tick from the 10-clock schedule, let the posedge
    // happen, then compare everything due at this negedge.
    task automatic cycle();
        tick  = (phase == 9);
        phase = (phase == 9) ? 0 : phase + 1;
        @(negedge clk);
        cyc++;
        tick = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check({sb[i].tag, ".state"}, 32'(state_o), 32'(sb[i].st));
                check({sb[i].tag, ".buzz"}, 32'(buzz), 32'(sb[i].bz));
                check({sb[i].tag, ".cnt"}, 32'(snooze_cnt_o), 32'(sb[i].cnt));
                sb.delete(i);
            end
        end
    endtask

    // Advance until the next cycle() will carry a tick.
    task automatic pre_tick();
        while (phase != 9) cycle();
    endtask

    task automatic pulse_snooze(input string tag, input int st, input logic bz, input int cnt);
        snooze = 1'b1;
        sb_push(tag, 1, st, bz, cnt);
        cycle();
        snooze = 1'b0;
    endtask

    task automatic pulse_stop(input string tag, input int cnt);
        stop = 1'b1;
        sb_push(tag, 1, S_DONE, 1'b0, cnt);
        cycle();
        stop = 1'b0;
    endtask

    // Drop match: one more edge in DONE while match_q clears, then IDLE.
    task automatic end_minute(input string tag, input int cnt);
        match = 1'b0;
        sb_push({tag, "_hold"}, 1, S_DONE, 1'b0, cnt);
        sb_push({tag, "_idle"}, 2, S_IDLE, 1'b0, 0);
        cycle();
        cycle();
    endtask

    function automatic logic ring_buzz_after(input int n_ticks);
`ifdef ALARM_SEQ_BEEP_EN
        return (n_ticks % 2) == 0;
`else
        return (n_ticks >= 0);
`endif
    endfunction

    initial begin
        rst     = 1'b0;
        tick    = 1'b0;
        alarmon = 1'b0;
        match   = 1'b0;
        snooze  = 1'b0;
        stop    = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst.state", 32'(state_o), S_IDLE);
        check("rst.buzz", 32'(buzz), 0);
        check("rst.cnt", 32'(snooze_cnt_o), 0);
        rst = 1'b1;
        cycle();

        // Basic ring: 1-clk latency, RING_S ticks, timeout, back to IDLE.
        alarmon = 1'b1;
        match   = 1'b1;
        sb_push("basic_entry", 1, S_RING, 1'b1, 0);
        cycle();
        for (int i = 1; i <= 3; i++) begin
            pre_tick();
            sb_push($sformatf("basic_tick%0d", i), 1, S_RING, ring_buzz_after(i), 0);
            cycle();
        end
        pre_tick();
        sb_push("basic_timeout", 1, S_DONE, 1'b0, 0);
        cycle();
        end_minute("basic", 0);

        // Snooze cycle, ignored snooze in SNOOZE, then snooze limit.
        match = 1'b1;
        sb_push("snz_entry", 1, S_RING, 1'b1, 0);
        cycle();
        pulse_snooze("snz_press1", S_SNOOZE, 1'b0, 1);
        pre_tick();
        sb_push("snz_t1", 1, S_SNOOZE, 1'b0, 1);
        cycle();
        pulse_snooze("snz_ignored", S_SNOOZE, 1'b0, 1);
        pre_tick();
        sb_push("snz_t2", 1, S_SNOOZE, 1'b0, 1);
        cycle();
        pre_tick();
        sb_push("snz_rering1", 1, S_RING, 1'b1, 1);
        cycle();
        pulse_snooze("snz_press2", S_SNOOZE, 1'b0, 2);
        for (int i = 1; i <= 2; i++) begin
            pre_tick();
            sb_push("snz2_wait", 1, S_SNOOZE, 1'b0, 2);
            cycle();
        end
        pre_tick();
        sb_push("snz_rering2", 1, S_RING, 1'b1, 2);
        cycle();
        pulse_snooze("snz_limit", S_DONE, 1'b0, 2);
        end_minute("snz_limit", 2);

        // Same-minute retrigger blocked; next match rise rings again.
        match = 1'b1;
        sb_push("rt_entry", 1, S_RING, 1'b1, 0);
        cycle();
        pulse_stop("rt_stop", 0);
        for (int i = 0; i < 50; i++) begin
            sb_push("rt_blocked", 1, S_DONE, 1'b0, 0);
            cycle();
        end
        end_minute("rt", 0);
        match = 1'b1;
        sb_push("rt_reentry", 1, S_RING, 1'b1, 0);
        cycle();
        pulse_stop("rt_stop2", 0);
        end_minute("rt2", 0);

        // Stop and snooze together: stop wins.
        match = 1'b1;
        sb_push("pri_entry", 1, S_RING, 1'b1, 0);
        cycle();
        stop   = 1'b1;
        snooze = 1'b1;
        sb_push("pri_stop_snooze", 1, S_DONE, 1'b0, 0);
        cycle();
        stop   = 1'b0;
        snooze = 1'b0;
        end_minute("pri", 0);

        // Tick and snooze together: the snooze load consumes the tick, so
        // SNOOZE lasts the full 3 ticks (countdown loaded with 2).
        match = 1'b1;
        sb_push("ts_entry", 1, S_RING, 1'b1, 0);
        cycle();
        pre_tick();
        pulse_snooze("ts_press", S_SNOOZE, 1'b0, 1);
        for (int i = 1; i <= 2; i++) begin
            pre_tick();
            sb_push($sformatf("ts_t%0d", i), 1, S_SNOOZE, 1'b0, 1);
            cycle();
        end
        pre_tick();
        sb_push("ts_t3", 1, S_RING, 1'b1, 1);
        cycle();

        // alarmon=0 during SNOOZE ends the session.
        pulse_snooze("aoff_press", S_SNOOZE, 1'b0, 2);
        alarmon = 1'b0;
        sb_push("aoff_snooze", 1, S_DONE, 1'b0, 2);
        cycle();
        end_minute("aoff", 2);

        // Match rise with alarm off, then alarmon 0->1 inside the minute: no ring.
        match = 1'b1;
        sb_push("off_rise", 1, S_IDLE, 1'b0, 0);
        cycle();
        alarmon = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb_push("on_in_minute", 1, S_IDLE, 1'b0, 0);
            cycle();
        end
        match = 1'b0;
        cycle();

        // Reset mid-RING drops buzz without waiting for a clock edge.
        match = 1'b1;
        sb_push("rst_entry", 1, S_RING, 1'b1, 0);
        cycle();
        cycle();
        #2 rst = 1'b0;
        #1;
        check("async_rst.buzz", 32'(buzz), 0);
        check("async_rst.state", 32'(state_o), S_IDLE);
        check("async_rst.cnt", 32'(snooze_cnt_o), 0);
        @(negedge clk);
        match = 1'b0;
        rst   = 1'b1;
        cycle();
        sb_push("post_rst", 1, S_IDLE, 1'b0, 0);
        cycle();

        check("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
